// File: rtl/avaliador_partitura_pkg.sv
// ============================================================================
// Module : avaliador_partitura_pkg
// Brief  : State codes and timing helper shared by the song-evaluation path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avaliador_partitura_pkg;

    localparam logic [3:0] c_OCIOSO    = 4'd0;
    localparam logic [3:0] c_LE_MEM    = 4'd1;
    localparam logic [3:0] c_DECIDE    = 4'd2;
    localparam logic [3:0] c_AGUARDA   = 4'd3;
    localparam logic [3:0] c_CAPTURA   = 4'd4;
    localparam logic [3:0] c_SEGURA    = 4'd5;
    localparam logic [3:0] c_PAUSA_MUS = 4'd6;
    localparam logic [3:0] c_AVALIA    = 4'd7;
    localparam logic [3:0] c_PROXIMO   = 4'd8;
    localparam logic [3:0] c_FIM       = 4'd9;

    // Absolute difference of two zero-extended beat counts.
    function automatic int unsigned dif_abs(input int unsigned a, input int unsigned b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/avaliador_partitura_captura.sv
// ============================================================================
// Module : captura_acorde
// Brief  : Chord-capture window timer plus OR-accumulating key-mask register.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module captura_acorde #(
    parameter int N_TECLAS = 12,
    parameter int JANELA   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_limpa,
    input  logic                i_acumula,
    input  logic [N_TECLAS-1:0] i_botoes,
    output logic [N_TECLAS-1:0] o_mascara,
    output logic                o_janela_fim
);

    localparam int c_TMR_W = (JANELA > 1) ? $clog2(JANELA) : 1;

    logic [c_TMR_W-1:0]  r_tmr;
    logic [N_TECLAS-1:0] r_mascara;
    logic                w_janela_fim;

    assign w_janela_fim = (r_tmr == c_TMR_W'(JANELA - 1));

    // Clearing with accumulate set loads the first key-down directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr     <= '0;
            r_mascara <= '0;
        end else if (i_limpa) begin
            r_tmr     <= '0;
            r_mascara <= i_acumula ? i_botoes : '0;
        end else if (i_acumula) begin
            r_mascara <= r_mascara | i_botoes;
            if (!w_janela_fim) r_tmr <= r_tmr + 1'b1;
        end
    end

    assign o_mascara    = r_mascara;
    assign o_janela_fim = w_janela_fim;

endmodule

`default_nettype wire

// File: rtl/avaliador_partitura.sv
// ============================================================================
// Module : avaliador_partitura
// Brief  : Walks a song in note memory, guides the player and scores each step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avaliador_partitura
    import avaliador_partitura_pkg::*;
#(
    parameter int N_TECLAS    = 12,
    parameter int ADDR_W      = 5,
    parameter int DUR_W       = 4,
    parameter int TOL         = 1,
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int JANELA      = CLOCK_FREQ / 50,
    parameter int TIMEOUT_BAT = 8,
    parameter int MAX_ERROS   = 7
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic                           pausa,
    input  logic                           tick_batida,
    input  logic [N_TECLAS-1:0]            botoes,
    input  logic [N_TECLAS-1:0]            mem_nota,
    input  logic [DUR_W-1:0]               mem_duracao,
    input  logic                           mem_fim,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [N_TECLAS-1:0]            leds_guia,
    output logic [ADDR_W:0]                acertos,
    output logic [$clog2(MAX_ERROS+1)-1:0] erros,
    output logic                           evento_acerto,
    output logic                           evento_erro,
    output logic                           ativo,
    output logic                           pronto,
    output logic                           falhou,
    output logic [3:0]                     db_estado
);

    localparam int c_ERR_W = $clog2(MAX_ERROS + 1);
    localparam int c_BAT_W = ($clog2(TIMEOUT_BAT + 1) > DUR_W + 1) ? $clog2(TIMEOUT_BAT + 1) : DUR_W + 1;

    logic [3:0]          r_estado, w_prox;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_acertos;
    logic [c_ERR_W-1:0]  r_erros;
    logic [c_BAT_W-1:0]  r_bat;
    logic [DUR_W-1:0]    r_seg;
    logic                r_forca_erro, r_forca_acerto;
    logic                r_ev_acerto, r_ev_erro;
    logic                r_ativo, r_pronto, r_falhou;

    logic                w_tecla, w_limpa, w_acumula, w_janela_fim, w_acerto;
    logic                w_timeout, w_fim_pausa;
    logic [N_TECLAS-1:0] w_mascara;
    logic [DUR_W-1:0]    w_dur;

    assign w_tecla     = |botoes;
    assign w_dur       = (mem_duracao == '0) ? DUR_W'(1) : mem_duracao;
    assign w_timeout   = (r_bat == c_BAT_W'(TIMEOUT_BAT));
    assign w_fim_pausa = (r_bat == c_BAT_W'(w_dur));
    assign w_acerto    = !r_forca_erro &&
                         (r_forca_acerto ||
                          ((w_mascara == mem_nota) &&
                           (dif_abs(32'(r_seg), 32'(w_dur)) <= $unsigned(TOL))));

    assign w_limpa   = !pausa && (r_estado == c_AGUARDA);
    assign w_acumula = !pausa && w_tecla && ((r_estado == c_AGUARDA) || (r_estado == c_CAPTURA));

    captura_acorde #(
        .N_TECLAS (N_TECLAS),
        .JANELA   (JANELA)
    ) u_captura (
        .clk          (clock),
        .rst_n        (reset),
        .i_limpa      (w_limpa),
        .i_acumula    (w_acumula),
        .i_botoes     (botoes),
        .o_mascara    (w_mascara),
        .o_janela_fim (w_janela_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_estado <= c_OCIOSO;
        else        r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        if (!pausa) begin
            case (r_estado)
                c_OCIOSO, c_FIM: if (iniciar) w_prox = c_LE_MEM;
                c_LE_MEM:        w_prox = c_DECIDE;
                c_DECIDE: begin
                    if (mem_fim)               w_prox = c_FIM;
                    else if (mem_nota == '0)   w_prox = c_PAUSA_MUS;
                    else                       w_prox = c_AGUARDA;
                end
                c_AGUARDA: begin
                    if (w_tecla)               w_prox = c_CAPTURA;
                    else if (w_timeout)        w_prox = c_AVALIA;
                end
                c_CAPTURA: begin
                    if (!w_tecla)              w_prox = c_AVALIA;
                    else if (w_janela_fim)     w_prox = c_SEGURA;
                end
                c_SEGURA:    if (!w_tecla) w_prox = c_AVALIA;
                c_PAUSA_MUS: if (w_tecla || w_fim_pausa) w_prox = c_AVALIA;
                c_AVALIA:    w_prox = c_PROXIMO;
                c_PROXIMO: begin
                    if ((r_erros == c_ERR_W'(MAX_ERROS)) || (r_addr == '1)) w_prox = c_FIM;
                    else                                                    w_prox = c_LE_MEM;
                end
                default:     w_prox = c_OCIOSO;
            endcase
        end
    end

    // Held time runs from the first key-down; a tick on the release cycle is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr         <= '0;
            r_acertos      <= '0;
            r_erros        <= '0;
            r_bat          <= '0;
            r_seg          <= '0;
            r_forca_erro   <= 1'b0;
            r_forca_acerto <= 1'b0;
            r_ev_acerto    <= 1'b0;
            r_ev_erro      <= 1'b0;
            r_ativo        <= 1'b0;
            r_pronto       <= 1'b0;
            r_falhou       <= 1'b0;
        end else begin
            r_ev_acerto <= 1'b0;
            r_ev_erro   <= 1'b0;
            if (!pausa) begin
                case (r_estado)
                    c_OCIOSO, c_FIM: begin
                        if (iniciar) begin
                            r_addr    <= '0;
                            r_acertos <= '0;
                            r_erros   <= '0;
                            r_pronto  <= 1'b0;
                            r_falhou  <= 1'b0;
                            r_ativo   <= 1'b1;
                        end
                    end
                    c_DECIDE: begin
                        r_bat          <= '0;
                        r_seg          <= '0;
                        r_forca_erro   <= 1'b0;
                        r_forca_acerto <= 1'b0;
                        if (mem_fim) begin
                            r_pronto <= 1'b1;
                            r_ativo  <= 1'b0;
                        end
                    end
                    c_AGUARDA: begin
                        if (w_tecla)          r_seg        <= tick_batida ? DUR_W'(1) : '0;
                        else if (w_timeout)   r_forca_erro <= 1'b1;
                        else if (tick_batida) r_bat        <= r_bat + 1'b1;
                    end
                    c_CAPTURA, c_SEGURA: begin
                        if (w_tecla && tick_batida && (r_seg != '1)) r_seg <= r_seg + 1'b1;
                    end
                    c_PAUSA_MUS: begin
                        if (w_tecla)          r_forca_erro   <= 1'b1;
                        else if (w_fim_pausa) r_forca_acerto <= 1'b1;
                        else if (tick_batida) r_bat          <= r_bat + 1'b1;
                    end
                    c_AVALIA: begin
                        if (w_acerto) begin
                            r_ev_acerto <= 1'b1;
                            if (r_acertos != '1) r_acertos <= r_acertos + 1'b1;
                        end else begin
                            r_ev_erro <= 1'b1;
                            r_erros   <= r_erros + 1'b1;
                        end
                    end
                    c_PROXIMO: begin
                        if (r_erros == c_ERR_W'(MAX_ERROS)) begin
                            r_falhou <= 1'b1;
                            r_pronto <= 1'b1;
                            r_ativo  <= 1'b0;
                        end else if (r_addr == '1) begin
                            r_pronto <= 1'b1;
                            r_ativo  <= 1'b0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr      = r_addr;
    assign leds_guia     = (!pausa && (r_estado == c_AGUARDA)) ? mem_nota : '0;
    assign acertos       = r_acertos;
    assign erros         = r_erros;
    assign evento_acerto = r_ev_acerto;
    assign evento_erro   = r_ev_erro;
    assign ativo         = r_ativo;
    assign pronto        = r_pronto;
    assign falhou        = r_falhou;
    assign db_estado     = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_avaliador_partitura.sv
// ============================================================================
// Module : tb_avaliador_partitura
// Brief  : Table-driven song steps with an event scoreboard, plus pause/abort/reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_avaliador_partitura;
    import avaliador_partitura_pkg::*;

    localparam int c_N    = 12;
    localparam int c_AW   = 5;
    localparam int c_DW   = 4;
    localparam int c_JAN  = 4;
    localparam int c_MAXE = 2;

    logic              clock = 1'b0, reset = 1'b0, iniciar = 1'b0, pausa = 1'b0, tick_batida = 1'b0;
    logic [c_N-1:0]    botoes = '0, mem_nota, leds_guia;
    logic [c_DW-1:0]   mem_duracao;
    logic              mem_fim;
    logic [c_AW-1:0]   mem_addr;
    logic [c_AW:0]     acertos;
    logic [1:0]        erros;
    logic              evento_acerto, evento_erro, ativo, pronto, falhou;
    logic [3:0]        db_estado;

    logic [c_N-1:0]    m_nota [32];
    logic [c_DW-1:0]   m_dur  [32];
    logic              m_fim  [32];

    int n_checks = 0;
    int n_pass   = 0;
    bit q_exp[$];

    avaliador_partitura #(
        .N_TECLAS(c_N), .ADDR_W(c_AW), .DUR_W(c_DW), .TOL(1), .CLOCK_FREQ(200),
        .JANELA(c_JAN), .TIMEOUT_BAT(8), .MAX_ERROS(c_MAXE)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausa(pausa), .tick_batida(tick_batida),
        .botoes(botoes), .mem_nota(mem_nota), .mem_duracao(mem_duracao), .mem_fim(mem_fim),
        .mem_addr(mem_addr), .leds_guia(leds_guia), .acertos(acertos), .erros(erros),
        .evento_acerto(evento_acerto), .evento_erro(evento_erro), .ativo(ativo),
        .pronto(pronto), .falhou(falhou), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous song RAM: data follows the address one cycle later.
    always @(posedge clock) begin
        mem_nota    <= m_nota[mem_addr];
        mem_duracao <= m_dur[mem_addr];
        mem_fim     <= m_fim[mem_addr];
    end

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
    endtask

    always @(negedge clock) begin
        if (evento_acerto || evento_erro) begin
            if (q_exp.size() == 0) begin
                check("evento_inesperado", {30'd0, evento_acerto, evento_erro}, 32'd0);
            end else begin
                bit e;
                e = q_exp.pop_front();
                check("evento", {30'd0, evento_acerto, evento_erro}, e ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulso_tick();
        tick_batida = 1'b1;
        cyc(1);
        tick_batida = 1'b0;
        cyc(2);
    endtask

    task automatic espera_estado(input logic [3:0] s, input string nome);
        int k = 0;
        while (db_estado !== s && k < 300) begin
            cyc(1);
            k++;
        end
        check(nome, 32'(db_estado), 32'(s));
    endtask

    task automatic espera_pronto(input string nome);
        int k = 0;
        while (pronto !== 1'b1 && k < 300) begin
            cyc(1);
            k++;
        end
        check(nome, 32'(pronto), 32'd1);
    endtask

    task automatic carrega(input int a, input logic [c_N-1:0] n, input logic [c_DW-1:0] d, input logic f);
        m_nota[a] = n;
        m_dur[a]  = d;
        m_fim[a]  = f;
    endtask

    task automatic inicia();
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
    endtask

    typedef struct {
        int             tipo;     // 0 press/hold, 1 wait ticks without keys, 2 key during rest
        logic [c_N-1:0] nota;
        logic [c_DW-1:0] dur;
        logic [c_N-1:0] teclas;
        int             ticks;
        bit             acerto;
    } vet_t;

    vet_t tab[10];

    initial begin
        for (int a = 0; a < 32; a++) carrega(a, '0, '0, 1'b1);
        tab[0] = '{0, 12'h010, 4'd2, 12'h010, 2, 1'b1};
        tab[1] = '{0, 12'h091, 4'd1, 12'h091, 1, 1'b1};
        tab[2] = '{0, 12'h091, 4'd1, 12'h011, 1, 1'b0};
        tab[3] = '{0, 12'h100, 4'd4, 12'h100, 1, 1'b0};
        tab[4] = '{0, 12'h100, 4'd4, 12'h100, 5, 1'b1};
        tab[5] = '{1, 12'h800, 4'd3, 12'h000, 8, 1'b0};
        tab[6] = '{1, 12'h000, 4'd2, 12'h000, 2, 1'b1};
        tab[7] = '{2, 12'h000, 4'd2, 12'h004, 0, 1'b0};
        tab[8] = '{0, 12'h001, 4'd0, 12'h001, 1, 1'b1};
        tab[9] = '{0, 12'h002, 4'd1, 12'h002, 3, 1'b0};

        cyc(3);
        check("rst_estado", 32'(db_estado), 32'(c_OCIOSO));
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_ativo_pronto_falhou", {29'd0, ativo, pronto, falhou}, 32'd0);
        check("rst_contadores", {24'd0, acertos, erros}, 32'd0);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 10; i++) begin
            carrega(0, tab[i].nota, tab[i].dur, 1'b0);
            carrega(1, '0, '0, 1'b1);
            inicia();
            espera_estado((tab[i].nota == '0) ? c_PAUSA_MUS : c_AGUARDA, $sformatf("v%0d_entrada", i));
            check($sformatf("v%0d_leds", i), 32'(leds_guia), 32'(tab[i].nota));
            q_exp.push_back(tab[i].acerto);
            case (tab[i].tipo)
                0: begin
                    for (int b = 0; b < c_N; b++) begin
                        if (tab[i].teclas[b]) begin
                            botoes[b] = 1'b1;
                            cyc(1);
                        end
                    end
                    repeat (tab[i].ticks) pulso_tick();
                    botoes = '0;
                end
                1: repeat (tab[i].ticks) pulso_tick();
                default: begin
                    botoes = tab[i].teclas;
                    cyc(2);
                    botoes = '0;
                end
            endcase
            espera_pronto($sformatf("v%0d_pronto", i));
            cyc(1);
            check($sformatf("v%0d_acertos", i), 32'(acertos), tab[i].acerto ? 32'd1 : 32'd0);
            check($sformatf("v%0d_erros", i), 32'(erros), tab[i].acerto ? 32'd0 : 32'd1);
            check($sformatf("v%0d_falhou_ativo", i), {30'd0, falhou, ativo}, 32'd0);
            check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'd1);
            check($sformatf("v%0d_fila", i), 32'(q_exp.size()), 32'd0);
        end

        // Two timeouts with MAX_ERROS=2 abort the song.
        carrega(0, 12'h001, 4'd1, 1'b0);
        carrega(1, 12'h002, 4'd1, 1'b0);
        carrega(2, '0, '0, 1'b1);
        inicia();
        espera_estado(c_AGUARDA, "to1_entrada");
        q_exp.push_back(1'b0);
        repeat (8) pulso_tick();
        cyc(3);
        espera_estado(c_AGUARDA, "to2_entrada");
        check("to1_addr", 32'(mem_addr), 32'd1);
        check("to1_erros", 32'(erros), 32'd1);
        q_exp.push_back(1'b0);
        repeat (8) pulso_tick();
        espera_pronto("to2_pronto");
        cyc(1);
        check("to2_falhou", 32'(falhou), 32'd1);
        check("to2_erros", 32'(erros), 32'd2);
        check("to2_addr", 32'(mem_addr), 32'd1);
        check("to2_ativo", 32'(ativo), 32'd0);

        // Pause freezes held time; start pulse mid-song is ignored.
        carrega(0, 12'h010, 4'd2, 1'b0);
        carrega(1, '0, '0, 1'b1);
        inicia();
        espera_estado(c_AGUARDA, "pa_entrada");
        check("pa_ativo", 32'(ativo), 32'd1);
        pausa = 1'b1;
        cyc(1);
        check("pa_leds_pausa", 32'(leds_guia), 32'd0);
        check("pa_estado_pausa", 32'(db_estado), 32'(c_AGUARDA));
        pausa = 1'b0;
        cyc(1);
        check("pa_leds", 32'(leds_guia), 32'h010);
        inicia();
        cyc(1);
        check("pa_iniciar_ignorado", 32'(db_estado), 32'(c_AGUARDA));
        q_exp.push_back(1'b1);
        botoes = 12'h010;
        pulso_tick();
        cyc(c_JAN + 2);
        check("pa_segura", 32'(db_estado), 32'(c_SEGURA));
        pausa = 1'b1;
        repeat (5) pulso_tick();
        cyc(85);
        check("pa_estado_congelado", 32'(db_estado), 32'(c_SEGURA));
        pausa = 1'b0;
        pulso_tick();
        botoes = '0;
        espera_pronto("pa_pronto");
        cyc(1);
        check("pa_acertos", 32'(acertos), 32'd1);
        check("pa_erros", 32'(erros), 32'd0);

        // Asynchronous reset mid-song.
        carrega(0, 12'h010, 4'd1, 1'b0);
        carrega(1, 12'h020, 4'd1, 1'b0);
        carrega(2, '0, '0, 1'b1);
        inicia();
        espera_estado(c_AGUARDA, "rs_entrada");
        q_exp.push_back(1'b1);
        botoes = 12'h010;
        pulso_tick();
        botoes = '0;
        cyc(3);
        espera_estado(c_AGUARDA, "rs_passo2");
        check("rs_acertos_antes", 32'(acertos), 32'd1);
        check("rs_leds_antes", 32'(leds_guia), 32'h020);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rs_estado", 32'(db_estado), 32'(c_OCIOSO));
        check("rs_leds", 32'(leds_guia), 32'd0);
        check("rs_contadores", {24'd0, acertos, erros}, 32'd0);
        check("rs_addr", 32'(mem_addr), 32'd0);
        check("rs_flags", {27'd0, ativo, pronto, falhou, evento_acerto, evento_erro}, 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(4);
        check("rs_fila", 32'(q_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
